cake_mover: RTL and testbench

- Produces the per-pixel overlap flags (cake[], border) that the collision/scoring FSM consumes.
- Owns position and direction state for N_CAKE moving cake sprites inside the arena.
- Once per frame, during vertical blanking, a serial update FSM advances every cake and bounces it off the arena walls.
- During scan-out it compares the current VGA coordinates against every sprite box and drives registered hit flags.

---
 rtl/game_pkg.sv | 45 ++++
 rtl/cake_mover_if.sv | 18 +
 rtl/sprite_hit.sv | 19 +
 rtl/cake_mover.sv | 125 ++++++++++++
 tb/tb_cake_mover.sv | 219 +++++++++++++++++++++
 5 files changed

// File: rtl/game_pkg.sv
// Shared arena geometry, VGA timing constants, sprite record and the
// bounce arithmetic used by the cake update FSM.
package game_pkg;

  localparam int unsigned H_ACTIVE    = 640;
  localparam int unsigned V_ACTIVE    = 480;
  localparam int unsigned SIZE        = 16;
  localparam int unsigned SPEED       = 2;
  localparam int unsigned ARENA_MIN_X = 16;
  localparam int unsigned ARENA_MAX_X = 623;
  localparam int unsigned ARENA_MIN_Y = 16;
  localparam int unsigned ARENA_MAX_Y = 463;

  typedef struct packed {
    logic [9:0] x;
    logic [9:0] y;
    logic       dx;
    logic       dy;
  } sprite_t;

  typedef enum logic {IDLE, UPDATE} state_t;

  // Returns {new_dir, new_pos}. Sums are taken 11 bits wide so they cannot wrap.
  function automatic logic [10:0] step_axis(input logic [9:0]  pos,
                                            input logic        dir,
                                            input int unsigned lo,
                                            input int unsigned hi,
                                            input int unsigned size,
                                            input int unsigned speed);
    logic [10:0] p;
    p = {1'b0, pos};
    if (dir) begin
      if (p + 11'(speed + size - 1) > 11'(hi))
        step_axis = {1'b0, 10'(hi - size + 1)};
      else
        step_axis = {1'b1, 10'(p + 11'(speed))};
    end else begin
      if (p < 11'(lo + speed))
        step_axis = {1'b1, 10'(lo)};
      else
        step_axis = {1'b0, 10'(p - 11'(speed))};
    end
  endfunction

endpackage

// File: rtl/cake_mover_if.sv
// Scan-position inputs and overlap/status outputs of the cake mover.
interface cake_mover_if #(parameter int unsigned N_CAKE = 8);

  logic [9:0]        xLength;
  logic [9:0]        yLength;
  logic              freeze;
  logic [N_CAKE-1:0] cake;
  logic              border;
  logic              busy;
  logic              overrun;

  modport master (output xLength, yLength, freeze,
                  input  cake, border, busy, overrun);

  modport slave  (input  xLength, yLength, freeze,
                  output cake, border, busy, overrun);

endinterface

// File: rtl/sprite_hit.sv
// Combinational box test of one square sprite against the scan position.
import game_pkg::*;

module sprite_hit #(
  parameter int unsigned SIZE = game_pkg::SIZE
) (
  input  logic [9:0] px,
  input  logic [9:0] py,
  input  logic [9:0] sx,
  input  logic [9:0] sy,
  output logic       hit
);

  always_comb begin
    hit = ({1'b0, px} >= {1'b0, sx}) && ({1'b0, px} < {1'b0, sx} + 11'(SIZE)) &&
          ({1'b0, py} >= {1'b0, sy}) && ({1'b0, py} < {1'b0, sy} + 11'(SIZE));
  end

endmodule

// File: rtl/cake_mover.sv
// Cake sprite positions: serial per-frame bounce update in vertical blanking,
// registered per-pixel overlap and border flags during scan-out.
import game_pkg::*;

module cake_mover #(
  parameter int unsigned N_CAKE      = 8,
  parameter int unsigned SIZE        = game_pkg::SIZE,
  parameter int unsigned SPEED       = game_pkg::SPEED,
  parameter int unsigned H_ACTIVE    = game_pkg::H_ACTIVE,
  parameter int unsigned V_ACTIVE    = game_pkg::V_ACTIVE,
  parameter int unsigned ARENA_MIN_X = game_pkg::ARENA_MIN_X,
  parameter int unsigned ARENA_MAX_X = game_pkg::ARENA_MAX_X,
  parameter int unsigned ARENA_MIN_Y = game_pkg::ARENA_MIN_Y,
  parameter int unsigned ARENA_MAX_Y = game_pkg::ARENA_MAX_Y
) (
  input logic        clk,
  input logic        rst,
  cake_mover_if.slave bus
);

  localparam int unsigned IDX_W = (N_CAKE > 1) ? $clog2(N_CAKE) : 1;

  for (genvar g = 0; g < N_CAKE; g++) begin : g_init_chk
    if (ARENA_MIN_X + 16 * g + SIZE - 1 > ARENA_MAX_X ||
        ARENA_MIN_Y + 48 * g + SIZE - 1 > ARENA_MAX_Y) begin : g_bad
      $fatal(1, "cake_mover: initial sprite position outside arena");
    end
  end

  state_t            state, state_n;
  logic [IDX_W-1:0]  idx, idx_n;
  sprite_t           spr [N_CAKE];
  sprite_t           spr_n;
  logic              cond, cond_d, frame_start;
  logic [N_CAKE-1:0] hit, cake_q;
  logic              border_n, border_q, overrun_q;

  function automatic sprite_t init_sprite(input int unsigned i);
    sprite_t s;
    s.x  = 10'(ARENA_MIN_X + 16 * i);
    s.y  = 10'(ARENA_MIN_Y + 48 * i);
    s.dx = i[0];
    s.dy = i[1];
    return s;
  endfunction

  assign cond        = (bus.yLength == 10'(V_ACTIVE)) && (bus.xLength == '0);
  assign frame_start = cond && !cond_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      idx   <= '0;
    end else begin
      state <= state_n;
      idx   <= idx_n;
    end
  end

  always_comb begin
    state_n = state;
    idx_n   = idx;
    case (state)
      IDLE: begin
        if (frame_start && !bus.freeze) begin
          state_n = UPDATE;
          idx_n   = '0;
        end
      end
      UPDATE: begin
        if (idx == IDX_W'(N_CAKE - 1)) begin
          state_n = IDLE;
          idx_n   = '0;
        end else begin
          idx_n = idx + 1'b1;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_comb begin
    spr_n = spr[idx];
    {spr_n.dx, spr_n.x} = step_axis(spr[idx].x, spr[idx].dx, ARENA_MIN_X, ARENA_MAX_X, SIZE, SPEED);
    {spr_n.dy, spr_n.y} = step_axis(spr[idx].y, spr[idx].dy, ARENA_MIN_Y, ARENA_MAX_Y, SIZE, SPEED);
  end

  always_comb begin
    border_n = ({1'b0, bus.xLength} < 11'(H_ACTIVE)) && ({1'b0, bus.yLength} < 11'(V_ACTIVE)) &&
               (({1'b0, bus.xLength} < 11'(ARENA_MIN_X)) || ({1'b0, bus.xLength} > 11'(ARENA_MAX_X)) ||
                ({1'b0, bus.yLength} < 11'(ARENA_MIN_Y)) || ({1'b0, bus.yLength} > 11'(ARENA_MAX_Y)));
  end

  for (genvar g = 0; g < N_CAKE; g++) begin : g_hit
    sprite_hit #(.SIZE(SIZE)) u_hit (
      .px  (bus.xLength),
      .py  (bus.yLength),
      .sx  (spr[g].x),
      .sy  (spr[g].y),
      .hit (hit[g])
    );
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cond_d    <= 1'b0;
      overrun_q <= 1'b0;
      cake_q    <= '0;
      border_q  <= 1'b0;
      for (int unsigned i = 0; i < N_CAKE; i++) spr[i] <= init_sprite(i);
    end else begin
      cond_d   <= cond;
      cake_q   <= hit;
      border_q <= border_n;
      if (frame_start && state == UPDATE) overrun_q <= 1'b1;
      if (state == UPDATE) spr[idx] <= spr_n;
    end
  end

  assign bus.cake    = cake_q;
  assign bus.border  = border_q;
  assign bus.busy    = (state == UPDATE);
  assign bus.overrun = overrun_q;

endmodule

// File: tb/tb_cake_mover.sv
// Self-checking bench for cake_mover: vector table, frame/bounce sequences
// and random pixels checked against an array-based sprite model.
module tb_cake_mover;

  localparam int N = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  cake_mover_if #(.N_CAKE(N)) bus ();
  cake_mover #(.N_CAKE(N)) dut (.clk(clk), .rst(rst), .bus(bus.slave));

  int n_cmp = 0;
  int n_fail = 0;
  int mx [N];
  int my [N];
  int mdx [N];
  int mdy [N];

  typedef struct {
    int x;
    int y;
    int exp_c0;
    int exp_border;
  } vec_t;

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input int x, input int y);
    bus.xLength = 10'(x);
    bus.yLength = 10'(y);
  endtask

  function automatic void model_reset();
    for (int i = 0; i < N; i++) begin
      mx[i]  = 16 + 16 * i;
      my[i]  = 16 + 48 * i;
      mdx[i] = i % 2;
      mdy[i] = (i / 2) % 2;
    end
  endfunction

  function automatic void axis(input int p_in, input int d_in, input int lo, input int hi,
                               output int p, output int d);
    p = p_in;
    d = d_in;
    if (d_in == 1) begin
      if (p_in + 2 + 16 - 1 > hi) begin p = hi - 16 + 1; d = 0; end
      else p = p_in + 2;
    end else begin
      if (p_in < lo + 2) begin p = lo; d = 1; end
      else p = p_in - 2;
    end
  endfunction

  function automatic void model_frame();
    int p, d;
    for (int i = 0; i < N; i++) begin
      axis(mx[i], mdx[i], 16, 623, p, d); mx[i] = p; mdx[i] = d;
      axis(my[i], mdy[i], 16, 463, p, d); my[i] = p; mdy[i] = d;
    end
  endfunction

  function automatic int model_cake(input int x, input int y);
    int v = 0;
    for (int i = 0; i < N; i++)
      if (x >= mx[i] && x < mx[i] + 16 && y >= my[i] && y < my[i] + 16) v |= (1 << i);
    return v;
  endfunction

  function automatic int model_border(input int x, input int y);
    return (x < 640 && y < 480 && (x < 16 || x > 623 || y < 16 || y > 463)) ? 1 : 0;
  endfunction

  task automatic pix_check(input string name, input int x, input int y);
    drive(x, y);
    step();
    chk($sformatf("%s_cake(%0d,%0d)", name, x, y), int'(bus.cake), model_cake(x, y));
    chk($sformatf("%s_border(%0d,%0d)", name, x, y), int'(bus.border), model_border(x, y));
  endtask

  task automatic probe(input int i);
    drive(mx[i], my[i]);           step(); chk($sformatf("spr%0d_tl_in", i), int'(bus.cake[i]), 1);
    drive(mx[i] - 1, my[i]);       step(); chk($sformatf("spr%0d_left_out", i), int'(bus.cake[i]), 0);
    drive(mx[i], my[i] - 1);       step(); chk($sformatf("spr%0d_above_out", i), int'(bus.cake[i]), 0);
    drive(mx[i] + 15, my[i] + 15); step(); chk($sformatf("spr%0d_br_in", i), int'(bus.cake[i]), 1);
    drive(mx[i] + 16, my[i]);      step(); chk($sformatf("spr%0d_right_out", i), int'(bus.cake[i]), 0);
  endtask

  task automatic frame(input bit frz);
    int bc;
    bc = 0;
    bus.freeze = frz;
    drive(0, 480);
    step();
    drive(0, 481);
    for (int c = 0; c < N + 6; c++) begin
      if (bus.busy) bc++;
      step();
    end
    bus.freeze = 1'b0;
    chk("busy_cycles", bc, frz ? 0 : N);
    if (!frz) model_frame();
  endtask

  vec_t vecs [12];
  int guard;

  initial begin
    vecs[0]  = '{16, 16, 1, 0};
    vecs[1]  = '{31, 31, 1, 0};
    vecs[2]  = '{32, 16, 0, 0};
    vecs[3]  = '{5, 100, 0, 1};
    vecs[4]  = '{100, 100, 0, 0};
    vecs[5]  = '{700, 100, 0, 0};
    vecs[6]  = '{0, 479, 0, 1};
    vecs[7]  = '{639, 0, 0, 1};
    vecs[8]  = '{640, 479, 0, 0};
    vecs[9]  = '{623, 463, 0, 0};
    vecs[10] = '{624, 463, 0, 1};
    vecs[11] = '{15, 15, 0, 1};

    bus.freeze = 1'b0;
    drive(100, 200);
    rst = 1'b1;
    repeat (3) step();
    chk("rst_cake", int'(bus.cake), 0);
    chk("rst_border", int'(bus.border), 0);
    chk("rst_busy", int'(bus.busy), 0);
    chk("rst_overrun", int'(bus.overrun), 0);
    rst = 1'b0;
    model_reset();

    for (int v = 0; v < 12; v++) begin
      drive(vecs[v].x, vecs[v].y);
      step();
      chk($sformatf("vec%0d_cake0", v), int'(bus.cake[0]), vecs[v].exp_c0);
      chk($sformatf("vec%0d_border", v), int'(bus.border), vecs[v].exp_border);
      chk($sformatf("vec%0d_cake", v), int'(bus.cake), model_cake(vecs[v].x, vecs[v].y));
    end
    probe(1);

    // first frame: sprite 0 bounces off both walls, sprite 1 moves to (34,62)
    frame(1'b0);
    probe(0);
    probe(1);

    for (int k = 0; k < 3; k++) frame(1'b1);
    chk("freeze_overrun", int'(bus.overrun), 0);
    for (int i = 0; i < N; i++) probe(i);

    // drive sprite 7 along +x up to the right wall and back
    guard = 0;
    while (mx[7] != 606 && guard < 400) begin
      frame(1'b0);
      guard++;
    end
    chk("reach_606_in_budget", (guard < 400) ? 1 : 0, 1);
    probe(7);
    frame(1'b0); probe(7);
    frame(1'b0); probe(7);
    frame(1'b0); probe(7);
    chk("overrun_before_seq", int'(bus.overrun), 0);

    // second frame start while the pass is running
    drive(0, 480); step();
    drive(1, 480); step();
    drive(0, 480); step();
    drive(0, 481);
    repeat (N + 4) step();
    model_frame();
    chk("overrun_set", int'(bus.overrun), 1);
    chk("overrun_busy_done", int'(bus.busy), 0);
    for (int i = 0; i < N; i++) probe(i);
    step();
    chk("overrun_sticky", int'(bus.overrun), 1);

    // reset in the middle of an update pass
    drive(0, 480); step();
    drive(0, 481); step(); step();
    chk("mid_busy", int'(bus.busy), 1);
    rst = 1'b1; step(); rst = 1'b0;
    model_reset();
    chk("midrst_busy", int'(bus.busy), 0);
    chk("midrst_overrun", int'(bus.overrun), 0);
    repeat (4) step();
    chk("midrst_stays_idle", int'(bus.busy), 0);
    for (int i = 0; i < N; i++) probe(i);

    for (int it = 0; it < 40; it++) begin
      frame($urandom_range(0, 3) == 0);
      for (int p = 0; p < 6; p++) begin
        int x, y;
        x = $urandom_range(0, 700);
        y = $urandom_range(0, 520);
        if (x == 0 && y == 480) y = 479;
        pix_check("rnd", x, y);
      end
    end
    for (int i = 0; i < N; i++) probe(i);
    chk("final_overrun", int'(bus.overrun), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
